// File: rtl/sram_pkg.sv
// Shared types and helpers for the multi-port SRAM and its read ports.
package sram_pkg;

   // Init/clear sweep controller states
   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } sram_state_e;

   localparam int MIN_READ_PORTS   = 1;
   localparam int MAX_READ_PORTS   = 4;
   localparam int MIN_READ_LATENCY = 1;
   localparam int MAX_READ_LATENCY = 2;

   // Number of independently writable words in one row
   function automatic int num_words(input int width, input int word_size);
      return width / word_size;
   endfunction

   // True when the parameter set describes a buildable array
   function automatic bit params_legal(input int width, input int word_size,
                                       input int num_read_ports, input int read_latency);
      return (word_size > 0) &&
             ((width % word_size) == 0) &&
             (num_read_ports >= MIN_READ_PORTS) && (num_read_ports <= MAX_READ_PORTS) &&
             (read_latency >= MIN_READ_LATENCY) && (read_latency <= MAX_READ_LATENCY);
   endfunction

endpackage

// File: rtl/sram_read_port.sv
// One read port: write-first forwarding, valid pipeline and optional output stage.
module sram_read_port
   import sram_pkg::*;
#(
   parameter int WIDTH        = 512,
   parameter int LOG_NUM_ROWS = 9,
   parameter int WORD_SIZE    = 64,
   parameter int READ_LATENCY = 1
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  accept,
   input  logic [LOG_NUM_ROWS-1:0]               rd_addr,
   input  logic [WIDTH-1:0]                      rd_row,
   input  logic [LOG_NUM_ROWS-1:0]               wr_addr,
   input  logic [WIDTH-1:0]                      wr_data,
   input  logic [num_words(WIDTH, WORD_SIZE)-1:0] wr_mask,
   output logic [WIDTH-1:0]                      read_data,
   output logic                                  read_valid
);

   localparam int NUM_WORDS = num_words(WIDTH, WORD_SIZE);

   logic [WIDTH-1:0] merged;
   logic [WIDTH-1:0] s1_data_q, s1_data_d;
   logic             s1_valid_q, s1_valid_d;

   // Overlay the words being written this cycle onto the stored row (write-first)
   always_comb begin
      merged = rd_row;
      if (rd_addr == wr_addr) begin
         for (int w = 0; w < NUM_WORDS; w++) begin
            if (wr_mask[w]) begin
               merged[w*WORD_SIZE +: WORD_SIZE] = wr_data[w*WORD_SIZE +: WORD_SIZE];
            end
         end
      end
   end

   // First stage captures data only on an accepted request so the output holds otherwise
   always_comb begin
      s1_valid_d = accept;
      s1_data_d  = accept ? merged : s1_data_q;
   end

   // First-stage registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic [WIDTH-1:0] s2_data_q, s2_data_d;
      logic             s2_valid_q, s2_valid_d;

      // Extra output stage, advances only when the first stage holds a result
      always_comb begin
         s2_valid_d = s1_valid_q;
         s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
      end

      // Output-stage registers
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
         end else begin
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
         end
      end

      assign read_data  = s2_data_q;
      assign read_valid = s2_valid_q;
   end else begin : g_lat1
      assign read_data  = s1_data_q;
      assign read_valid = s1_valid_q;
   end

endmodule

// File: rtl/sram_mport.sv
// Multi-read-port SRAM with per-word writes, write-first forwarding and a sequential init sweep.
module sram_mport
   import sram_pkg::*;
#(
   parameter int               WIDTH          = 512,
   parameter int               LOG_NUM_ROWS   = 9,
   parameter int               WORD_SIZE      = 64,
   parameter int               NUM_READ_PORTS = 2,
   parameter int               READ_LATENCY   = 1,
   parameter logic [WIDTH-1:0] INIT_VALUE     = '0
) (
   input  logic                                      clk,
   input  logic                                      reset,
   output logic                                      ready,
   input  logic                                      clearReq,
   input  logic [NUM_READ_PORTS-1:0]                 readEnable,
   input  logic [NUM_READ_PORTS-1:0][LOG_NUM_ROWS-1:0] readAddr,
   output logic [NUM_READ_PORTS-1:0][WIDTH-1:0]      readData,
   output logic [NUM_READ_PORTS-1:0]                 readValid,
   input  logic [LOG_NUM_ROWS-1:0]                   writeAddr,
   input  logic [WIDTH-1:0]                          writeData,
   input  logic [WIDTH/WORD_SIZE-1:0]                writeEnable
);

   localparam int                    NUM_ROWS  = 2**LOG_NUM_ROWS;
   localparam int                    NUM_WORDS = num_words(WIDTH, WORD_SIZE);
   localparam logic [LOG_NUM_ROWS-1:0] LAST_ROW = '1;

   if (!params_legal(WIDTH, WORD_SIZE, NUM_READ_PORTS, READ_LATENCY)) begin : g_bad_params
      $error("sram_mport: illegal parameters (WIDTH%%WORD_SIZE, NUM_READ_PORTS 1..4, READ_LATENCY 1..2)");
   end

   sram_state_e             state_q, state_d;
   logic [LOG_NUM_ROWS-1:0] cnt_q, cnt_d;
   logic                    ready_q, ready_d;

   logic [WIDTH-1:0]        mem_q [NUM_ROWS];

   logic                    wr_en;
   logic [LOG_NUM_ROWS-1:0] wr_row;
   logic [WIDTH-1:0]        wr_data;
   logic [NUM_WORDS-1:0]    wr_mask;
   logic [NUM_WORDS-1:0]    fwd_mask;
   logic [NUM_READ_PORTS-1:0][WIDTH-1:0] rd_rows;

   // Sweep controller next state and selection between sweep writes and user writes
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_en   = 1'b0;
      wr_row  = writeAddr;
      wr_data = writeData;
      wr_mask = '0;
      case (state_q)
         INIT: begin
            wr_en   = 1'b1;
            wr_row  = cnt_q;
            wr_data = INIT_VALUE;
            wr_mask = '1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_ROW) begin
               state_d = READY;
            end
         end
         READY: begin
            if (|writeEnable) begin
               wr_en   = 1'b1;
               wr_mask = writeEnable;
            end
            if (clearReq) begin
               state_d = INIT;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = INIT;
            cnt_d   = '0;
         end
      endcase
      ready_d = (state_d == READY);
   end

   // Controller state, sweep counter and registered ready flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= INIT;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
      end
   end

   // Storage array; contents are deliberately not reset, the sweep initialises them
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int w = 0; w < NUM_WORDS; w++) begin
            if (wr_mask[w]) begin
               mem_q[wr_row][w*WORD_SIZE +: WORD_SIZE] <= wr_data[w*WORD_SIZE +: WORD_SIZE];
            end
         end
      end
   end

   // Stored row seen by each port and the write strobes eligible for forwarding
   always_comb begin
      for (int p = 0; p < NUM_READ_PORTS; p++) begin
         rd_rows[p] = mem_q[readAddr[p]];
      end
      fwd_mask = (state_q == READY) ? writeEnable : '0;
   end

   assign ready = ready_q;

   for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
      sram_read_port #(
         .WIDTH        (WIDTH),
         .LOG_NUM_ROWS (LOG_NUM_ROWS),
         .WORD_SIZE    (WORD_SIZE),
         .READ_LATENCY (READ_LATENCY)
      ) u_port (
         .clk        (clk),
         .reset      (reset),
         .accept     (ready_q & readEnable[p]),
         .rd_addr    (readAddr[p]),
         .rd_row     (rd_rows[p]),
         .wr_addr    (writeAddr),
         .wr_data    (writeData),
         .wr_mask    (fwd_mask),
         .read_data  (readData[p]),
         .read_valid (readValid[p])
      );
   end

endmodule

// File: tb/tb_sram_mport.sv
// Directed bench for sram_mport: one latency-1 instance and one latency-2 instance share stimulus.
module tb_sram_mport;

   localparam logic [511:0] INIT2 = {8{64'hC3C3_0F0F_1234_5678}};
   localparam logic [511:0] PAT_A5 = {8{64'hA5A5_A5A5_A5A5_A5A5}};
   localparam logic [511:0] PAT_11 = {8{64'h1111_1111_1111_1111}};
   localparam logic [511:0] PAT_22 = {8{64'h2222_2222_2222_2222}};
   localparam logic [511:0] PAT_DD = {8{64'hDEAD_BEEF_DEAD_BEEF}};

   logic               clk = 1'b0;
   logic               reset;
   logic               clearReq;
   logic [1:0]         readEnable;
   logic [1:0][8:0]    readAddr;
   logic [8:0]         writeAddr;
   logic [511:0]       writeData;
   logic [7:0]         writeEnable;

   logic               ready1, ready2;
   logic [1:0][511:0]  readData1, readData2;
   logic [1:0]         readValid1, readValid2;

   int checkCount = 0;
   int errorCount = 0;

   sram_mport #(.READ_LATENCY(1), .INIT_VALUE('0)) dut1 (
      .clk         (clk),
      .reset       (reset),
      .ready       (ready1),
      .clearReq    (clearReq),
      .readEnable  (readEnable),
      .readAddr    (readAddr),
      .readData    (readData1),
      .readValid   (readValid1),
      .writeAddr   (writeAddr),
      .writeData   (writeData),
      .writeEnable (writeEnable)
   );

   sram_mport #(.READ_LATENCY(2), .INIT_VALUE(INIT2)) dut2 (
      .clk         (clk),
      .reset       (reset),
      .ready       (ready2),
      .clearReq    (clearReq),
      .readEnable  (readEnable),
      .readAddr    (readAddr),
      .readData    (readData2),
      .readValid   (readValid2),
      .writeAddr   (writeAddr),
      .writeData   (writeData),
      .writeEnable (writeEnable)
   );

   always #5 clk = ~clk;

   // Advance one clock and settle just after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Count a comparison and report a mismatch
   task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drive every DUT input in one go
   task automatic applyStimulus(input logic [1:0] re, input logic [8:0] a0, input logic [8:0] a1,
                                input logic [7:0] we, input logic [8:0] wa, input logic [511:0] wd,
                                input logic clr);
      readEnable  = re;
      readAddr[0] = a0;
      readAddr[1] = a1;
      writeEnable = we;
      writeAddr   = wa;
      writeData   = wd;
      clearReq    = clr;
   endtask

   // Step until ready rises, bounded so a stuck sweep still reaches the summary
   task automatic waitReady(output int n);
      n = 0;
      while (!ready1 && n < 1000) begin
         step();
         n++;
      end
   endtask

   function automatic logic [511:0] rowPattern(input int r);
      logic [63:0] w;
      w = 64'h0BAD_F00D_0000_0000 + 64'(r);
      return {8{w}};
   endfunction

   initial begin
      int n;
      reset = 1'b1;
      applyStimulus(2'b00, 9'd0, 9'd0, 8'h00, 9'd0, '0, 1'b0);
      repeat (3) step();
      checkOutput("rstReady1", 512'(ready1), 512'd0);
      checkOutput("rstReady2", 512'(ready2), 512'd0);
      checkOutput("rstValid1", 512'(readValid1), 512'd0);
      checkOutput("rstValid2", 512'(readValid2), 512'd0);
      checkOutput("rstData2p0", readData2[0], '0);

      reset = 1'b0;
      waitReady(n);
      checkOutput("initLen", 512'(n), 512'd512);
      checkOutput("initReady2", 512'(ready2), 512'd1);

      // Read of the last row after the sweep
      applyStimulus(2'b11, 9'd511, 9'd0, 8'h00, 9'd0, '0, 1'b0);
      step();
      applyStimulus(2'b00, 9'd0, 9'd0, 8'h00, 9'd0, '0, 1'b0);
      checkOutput("r511Valid1", 512'(readValid1), 512'd3);
      checkOutput("r511Data1", readData1[0], '0);
      checkOutput("r511Lat2Early", 512'(readValid2), 512'd0);
      step();
      checkOutput("r511Pulse1", 512'(readValid1), 512'd0);
      checkOutput("r511Valid2", 512'(readValid2), 512'd3);
      checkOutput("r511Data2", readData2[0], INIT2);
      checkOutput("r0Data2p1", readData2[1], INIT2);

      // Full-row write then read back
      applyStimulus(2'b00, 9'd0, 9'd0, 8'hFF, 9'd5, PAT_A5, 1'b0);
      step();
      applyStimulus(2'b01, 9'd5, 9'd0, 8'h00, 9'd0, '0, 1'b0);
      step();
      applyStimulus(2'b00, 9'd0, 9'd0, 8'h00, 9'd0, '0, 1'b0);
      checkOutput("wr5Valid", 512'(readValid1), 512'd1);
      checkOutput("wr5Data", readData1[0], PAT_A5);

      // Same-cycle partial write and read: per-word write-first
      applyStimulus(2'b00, 9'd0, 9'd0, 8'hFF, 9'd7, PAT_22, 1'b0);
      step();
      applyStimulus(2'b11, 9'd7, 9'd7, 8'h0F, 9'd7, PAT_11, 1'b0);
      step();
      applyStimulus(2'b00, 9'd0, 9'd0, 8'h00, 9'd0, '0, 1'b0);
      checkOutput("fwdP1", readData1[1], {PAT_22[511:256], PAT_11[255:0]});
      checkOutput("fwdP0", readData1[0], {PAT_22[511:256], PAT_11[255:0]});
      step();
      checkOutput("holdValid", 512'(readValid1), 512'd0);
      checkOutput("holdData", readData1[1], {PAT_22[511:256], PAT_11[255:0]});
      checkOutput("fwdLat2P1", readData2[1], {PAT_22[511:256], PAT_11[255:0]});

      // Distinct rows 0..9, then back-to-back reads on both ports
      for (int r = 0; r < 10; r++) begin
         applyStimulus(2'b00, 9'd0, 9'd0, 8'hFF, 9'(r), rowPattern(r), 1'b0);
         step();
      end
      for (int k = 0; k < 12; k++) begin
         if (k < 10) applyStimulus(2'b11, 9'(k), 9'(9 - k), 8'h00, 9'd0, '0, 1'b0);
         else        applyStimulus(2'b00, 9'd0, 9'd0, 8'h00, 9'd0, '0, 1'b0);
         step();
         checkOutput($sformatf("pipeV1_%0d", k), 512'(readValid1), (k < 10) ? 512'd3 : 512'd0);
         if (k < 10) begin
            checkOutput($sformatf("pipeD1p0_%0d", k), readData1[0], rowPattern(k));
         end
         checkOutput($sformatf("pipeV2_%0d", k), 512'(readValid2), (k >= 1 && k <= 10) ? 512'd3 : 512'd0);
         if (k >= 1 && k <= 10) begin
            checkOutput($sformatf("pipeD2p0_%0d", k), readData2[0], rowPattern(k - 1));
            checkOutput($sformatf("pipeD2p1_%0d", k), readData2[1], rowPattern(10 - k));
         end
      end

      // Clear sweep: write dropped, extra clear ignored, row 3 back to init value
      applyStimulus(2'b00, 9'd0, 9'd0, 8'h00, 9'd0, '0, 1'b1);
      step();
      applyStimulus(2'b00, 9'd0, 9'd0, 8'h00, 9'd0, '0, 1'b0);
      checkOutput("clrDrop", 512'(ready1), 512'd0);
      n = 0;
      while (!ready1 && n < 1000) begin
         applyStimulus(2'b00, 9'd0, 9'd0, (n == 100) ? 8'hFF : 8'h00, 9'd3, PAT_DD, (n == 50));
         step();
         n++;
      end
      applyStimulus(2'b00, 9'd0, 9'd0, 8'h00, 9'd0, '0, 1'b0);
      checkOutput("clrLen", 512'(n), 512'd512);
      applyStimulus(2'b01, 9'd3, 9'd0, 8'h00, 9'd0, '0, 1'b0);
      step();
      applyStimulus(2'b00, 9'd0, 9'd0, 8'h00, 9'd0, '0, 1'b0);
      checkOutput("clrRow3d1", readData1[0], '0);
      step();
      checkOutput("clrRow3d2", readData2[0], INIT2);

      // Reset in the middle of a sweep restarts it
      applyStimulus(2'b00, 9'd0, 9'd0, 8'h00, 9'd0, '0, 1'b1);
      step();
      applyStimulus(2'b00, 9'd0, 9'd0, 8'h00, 9'd0, '0, 1'b0);
      repeat (200) step();
      reset = 1'b1;
      #1;
      checkOutput("midRstReady", 512'(ready1), 512'd0);
      checkOutput("midRstData2", readData2[0], '0);
      step();
      reset = 1'b0;
      waitReady(n);
      checkOutput("midRstLen", 512'(n), 512'd512);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/sram_mport.md
Name: sram_mport

Overview:
- Parametrised successor to the single-read-port cache/data SRAM.
- Adds N independent read ports, per-word write-first forwarding, and a selectable read latency of 1 or 2.
- Replaces the instantaneous reset loop with a sequential init/clear sweep, qualified by a ready flag.
- Sits under cache data/tag arrays and register-file-like storage. Callers must gate traffic on ready.

Parameters:
- WIDTH, 512, row width in bits; must be a multiple of WORD_SIZE
- LOG_NUM_ROWS, 9, log2 of row count; NUM_ROWS = 2**LOG_NUM_ROWS
- WORD_SIZE, 64, write-enable granularity in bits
- NUM_READ_PORTS, 2, independent read ports, 1..4
- READ_LATENCY, 1, cycles from readEnable to readValid; legal values 1 or 2
- INIT_VALUE, 0, WIDTH-bit value written to every row by the init/clear sweep

Ports:
- clk  input  1  clock; all state on posedge
- reset  input  1  asynchronous, active-high reset
- ready  output  1  high when the array accepts reads and writes
- clearReq  input  1  single-cycle request to re-run the init sweep
- readEnable  input  NUM_READ_PORTS  per-port read request
- readAddr  input  NUM_READ_PORTS x LOG_NUM_ROWS  per-port row address
- readData  output  NUM_READ_PORTS x WIDTH  per-port read data
- readValid  output  NUM_READ_PORTS  per-port data-valid strobe
- writeAddr  input  LOG_NUM_ROWS  write row address
- writeData  input  WIDTH  write data
- writeEnable  input  WIDTH/WORD_SIZE  per-word write strobes

Behaviour:
- Reset (async assert):
  - ready=0, readValid=0, readData=0, sweep counter=0, FSM=INIT.
  - Array contents are not reset directly.
- FSM states:
  - INIT: on each posedge, write INIT_VALUE to row[cnt] and increment cnt. Exit to READY after row NUM_ROWS-1, so the sweep takes exactly NUM_ROWS cycles. ready goes high on the following cycle.
  - READY: normal operation. clearReq=1 sets cnt=0, goes to INIT, and drops ready the next cycle.
  - clearReq during INIT is ignored; the sweep is not restarted.
  - Reset asserted mid-sweep returns to INIT with cnt=0.
- While ready=0:
  - writeEnable is ignored.
  - readEnable is ignored; readValid stays 0.
  - Reads in flight when clearReq is accepted still complete.
- Write:
  - In READY, for every i with writeEnable[i]=1, mem[writeAddr][i*WORD_SIZE +: WORD_SIZE] takes writeData of the same slice at the posedge.
  - writeEnable=0 is a no-op.
- Read, READ_LATENCY=1:
  - readEnable[p] at edge t gives readValid[p]=1 and readData[p] valid after edge t.
  - readValid is a one-cycle pulse per request.
- Read, READ_LATENCY=2:
  - An extra output register stage is added.
  - Valid and data appear one cycle later. Back-to-back requests are fully pipelined at one per cycle per port.
- readData holds its last value when readValid=0; it is not cleared.
- Same-cycle read and write to the same row (write-first):
  - Words with writeEnable=1 return the new writeData.
  - Words with writeEnable=0 return the old contents.
  - This is resolved per word and independently per port.
- Multiple ports reading the same row in the same cycle is legal; all return identical data.
- Address width is exact; there is no out-of-range case.

Decomposition:
- Shared package sram_pkg holds:
  - the FSM state enum {INIT, READY}
  - a function computing the number of words (WIDTH/WORD_SIZE)
  - a parameter legality check macro/assertion, covering READ_LATENCY in {1,2}, WIDTH%WORD_SIZE==0 and NUM_READ_PORTS in 1..4
- One natural sub-module: sram_read_port.
  - Instantiated NUM_READ_PORTS times.
  - Contains the write-first forwarding mux, valid pipeline and optional output stage.
- The top level holds the array, the write logic and the init FSM.

Test Plan:
- Reset release, default parameters, INIT_VALUE=0 -> ready=0 for exactly 512 cycles, ready=1 on cycle 513; a read of row 511 returns 0.
- In READY, write row 5 with all words 0xA5A5_A5A5_A5A5_A5A5 and writeEnable=8'hFF; next cycle, port0 reads row 5 -> readValid[0]=1 one cycle later with data all 0xA5A5...
- Same-cycle write to row 7 with writeEnable=8'h0F and new=all 0x11, old=all 0x22; port1 reads row 7 -> words 0-3 read 0x11, words 4-7 read 0x22.
- READ_LATENCY=2, reads on both ports every cycle for 10 cycles to rows 0..9 -> 10 consecutive readValid pulses per port, each two cycles after its request, with data in order.
- After writing row 3, pulse clearReq -> ready drops next cycle. A write issued during the sweep is dropped. After 512 cycles, row 3 reads INIT_VALUE.
- Assert reset at sweep cycle 200 -> ready stays 0, the counter restarts, and ready rises 512 cycles after reset deassert.
